flit_injector: RTL and testbench

//  Local-port packet transmitter: the requesting side of the router's 5-port round-robin arbiter.

---
 rtl/flit_injector.sv | 146 ++++++++++++++
 tb/tb_flit_injector.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_injector.sv
// Local-port flit transmitter: requests the router arbiter, then sends header/body/tail flits.
// Optional INJ_STATS_EN adds saturating pkt_count/stall_count outputs.
//   state | meaning
//   IDLE  | waiting for a packet descriptor
//   REQ   | req raised, waiting for first grant
//   HEAD  | header flit pending, sent on grant
//   BODY  | payload flits, one per grant && data_valid cycle
//   GAP   | one cycle with req low so the arbiter rotates
module flit_injector #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_start,
  input  logic [11:0]       pkt_len,
  input  logic [DEST_W-1:0] pkt_dest,
  output logic              start_ack,
  output logic              err,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              req,
  input  logic              grant,
  output logic              flit_valid,
  output logic [2:0]        flit_id,
  output logic [DATA_W-1:0] flit_data,
  output logic [11:0]       length
`ifdef INJ_STATS_EN
  ,
  output logic [15:0]       pkt_count,
  output logic [15:0]       stall_count
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, HEAD, BODY, GAP} state_t;

  state_t              state_q, state_d;
  logic [11:0]         rem_q, rem_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic                req_d, flit_valid_d, start_ack_d, err_d, data_ready_d;
  logic [2:0]          flit_id_d;
  logic [DATA_W-1:0]   flit_data_d;
  logic [11:0]         length_d;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    dest_d       = dest_q;
    start_ack_d  = 1'b0;
    err_d        = 1'b0;
    data_ready_d = 1'b0;
    flit_valid_d = 1'b0;
    flit_id_d    = 3'b000;
    flit_data_d  = flit_data;
    length_d     = length;
    case (state_q)
      IDLE: begin
        if (pkt_start) begin
          if (pkt_len == 12'd0 || pkt_len == 12'hFFF) begin
            err_d = 1'b1;
          end else begin
            start_ack_d = 1'b1;
            rem_d       = pkt_len;
            dest_d      = pkt_dest;
            state_d     = REQ;
          end
        end
      end
      REQ: if (grant) state_d = HEAD;
      HEAD: begin
        if (grant) begin
          flit_valid_d = 1'b1;
          flit_id_d    = 3'b001;
          flit_data_d  = DATA_W'(dest_q);
          length_d     = rem_q + 12'd1;
          state_d      = BODY;
        end
      end
      BODY: begin
        // rem_q is at least 1 here, so the decrement never wraps
        if (grant && data_valid) begin
          flit_valid_d = 1'b1;
          data_ready_d = 1'b1;
          flit_data_d  = data_in;
          rem_d        = rem_q - 12'd1;
          if (rem_q == 12'd1) begin
            flit_id_d = 3'b100;
            state_d   = GAP;
          end else begin
            flit_id_d = 3'b010;
          end
        end
      end
      GAP: begin
        state_d  = IDLE;
        length_d = 12'd0;
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ) || (state_d == HEAD) || (state_d == BODY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      dest_q     <= '0;
      req        <= 1'b0;
      flit_valid <= 1'b0;
      start_ack  <= 1'b0;
      err        <= 1'b0;
      data_ready <= 1'b0;
      flit_id    <= 3'b000;
      flit_data  <= '0;
      length     <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      dest_q     <= dest_d;
      req        <= req_d;
      flit_valid <= flit_valid_d;
      start_ack  <= start_ack_d;
      err        <= err_d;
      data_ready <= data_ready_d;
      flit_id    <= flit_id_d;
      flit_data  <= flit_data_d;
      length     <= length_d;
    end
  end

`ifdef INJ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (flit_valid_d && flit_id_d == 3'b100 && pkt_count != 16'hFFFF)
        pkt_count <= pkt_count + 16'd1;
      if ((state_q == HEAD || state_q == BODY) && !flit_valid_d && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Bench for flit_injector: packet-level reference model checked every cycle, directed and random traffic.
module tb_flit_injector;
  localparam int DATA_W = 32;
  localparam int DEST_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pkt_start = 1'b0;
  logic [11:0]       pkt_len = '0;
  logic [DEST_W-1:0] pkt_dest = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              grant = 1'b0;
  logic              start_ack, err, data_ready, req, flit_valid;
  logic [2:0]        flit_id;
  logic [DATA_W-1:0] flit_data;
  logic [11:0]       length;
`ifdef INJ_STATS_EN
  logic [15:0]       pkt_count, stall_count;
`endif

  flit_injector #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
    .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_len(pkt_len), .pkt_dest(pkt_dest),
    .start_ack(start_ack), .err(err), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .req(req), .grant(grant), .flit_valid(flit_valid),
    .flit_id(flit_id), .flit_data(flit_data), .length(length)
`ifdef INJ_STATS_EN
    , .pkt_count(pkt_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a packet is len+1 flits; mode 0 idle, 1 awaiting first grant,
  // 2 sending (flit k goes out on grant, payload flits also need data_valid), 3 rotation gap.
  int                m_mode, m_len, m_sent, m_pkts, m_stalls;
  logic [DEST_W-1:0] m_dest;
  logic              e_req, e_valid, e_ack, e_err, e_ready;
  logic [2:0]        e_id;
  logic [DATA_W-1:0] e_data;
  logic [11:0]       e_length;

  int                cap_id[$];
  logic [DATA_W-1:0] cap_data[$];
  int                cap_len, n_ack, n_err;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_len = 0; m_sent = 0; m_dest = '0; m_pkts = 0; m_stalls = 0;
    e_req = 0; e_valid = 0; e_ack = 0; e_err = 0; e_ready = 0;
    e_id = 3'b000; e_length = '0; e_data = '0;
  endfunction

  function automatic void model_step();
    e_ack = 0; e_err = 0; e_valid = 0; e_ready = 0; e_id = 3'b000;
    case (m_mode)
      0: if (pkt_start) begin
        if (pkt_len == 0 || pkt_len == 4095) e_err = 1;
        else begin
          e_ack = 1; m_len = int'(pkt_len); m_dest = pkt_dest; m_sent = 0; m_mode = 1;
        end
      end
      1: if (grant) m_mode = 2;
      2: begin
        if (grant && (m_sent == 0 || data_valid)) begin
          e_valid = 1;
          if (m_sent == 0) begin
            e_id = 3'b001; e_data = DATA_W'(m_dest); e_length = 12'(m_len + 1);
          end else begin
            e_ready = 1; e_data = data_in;
            e_id = (m_sent == m_len) ? 3'b100 : 3'b010;
            if (m_sent == m_len) m_pkts++;
          end
          m_sent++;
          if (m_sent == m_len + 1) m_mode = 3;
        end else begin
          m_stalls++;
        end
      end
      default: begin m_mode = 0; e_length = '0; end
    endcase
    e_req = (m_mode == 1 || m_mode == 2);
  endfunction

  task automatic compare();
    chk("req", 32'(req), 32'(e_req));
    chk("flit_valid", 32'(flit_valid), 32'(e_valid));
    chk("flit_id", 32'(flit_id), 32'(e_id));
    chk("data_ready", 32'(data_ready), 32'(e_ready));
    chk("start_ack", 32'(start_ack), 32'(e_ack));
    chk("err", 32'(err), 32'(e_err));
    chk("length", 32'(length), 32'(e_length));
    if (e_valid) chk("flit_data", flit_data, e_data);
`ifdef INJ_STATS_EN
    chk("pkt_count", 32'(pkt_count), 32'(m_pkts));
    chk("stall_count", 32'(stall_count), 32'(m_stalls));
`endif
    if (flit_valid) begin
      cap_id.push_back(int'(flit_id));
      cap_data.push_back(flit_data);
      if (flit_id == 3'b001) cap_len = int'(length);
    end
    if (start_ack) n_ack++;
    if (err) n_err++;
  endtask

  task automatic step();
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
    data_in = $urandom();
  endtask

  task automatic clear_cap();
    cap_id.delete(); cap_data.delete(); cap_len = -1; n_ack = 0; n_err = 0;
  endtask

  task automatic check_ids(string name, input int exp[$]);
    chk({name, "_count"}, 32'(cap_id.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap_id.size(); i++)
      chk(name, 32'(cap_id[i]), 32'(exp[i]));
  endtask

  task automatic launch(input int len, input int dest);
    pkt_start = 1; pkt_len = 12'(len); pkt_dest = DEST_W'(dest);
    step();
    pkt_start = 0;
  endtask

  function automatic int count_id(int id);
    int n = 0;
    foreach (cap_id[i]) if (cap_id[i] == id) n++;
    return n;
  endfunction

  initial begin
    int exp_ids[$];
    int dropped;
    model_reset();
    clear_cap();
    @(negedge clk);
    chk("rst_req", 32'(req), 0);
    chk("rst_flit_valid", 32'(flit_valid), 0);
    chk("rst_flit_id", 32'(flit_id), 0);
    chk("rst_flit_data", flit_data, 0);
    chk("rst_length", 32'(length), 0);
    rst = 0;
    grant = 1; data_valid = 1;
    step();

    // pkt_len=3, dest=5, grant and data always available
    clear_cap();
    launch(3, 5);
    repeat (8) step();
    exp_ids = '{1, 2, 2, 4};
    check_ids("ids_len3", exp_ids);
    if (cap_data.size() > 0) chk("hdr_data_len3", cap_data[0], 32'd5);
    chk("length_len3", 32'(cap_len), 32'd4);
    chk("ack_len3", 32'(n_ack), 1);

    // single-word packet: header then tail only
    clear_cap();
    launch(1, 9);
    repeat (6) step();
    exp_ids = '{1, 4};
    check_ids("ids_len1", exp_ids);
    chk("length_len1", 32'(cap_len), 32'd2);

    // illegal lengths
    clear_cap();
    launch(0, 1);
    step();
    launch(4095, 1);
    repeat (3) step();
    chk("err_pulses", 32'(n_err), 2);
    chk("err_no_ack", 32'(n_ack), 0);

    // grant withdrawn for 5 cycles after the 2nd body flit
    clear_cap();
    dropped = 0;
    launch(4, 3);
    for (int i = 0; i < 30; i++) begin
      if (dropped == 0 && count_id(2) == 2) begin
        dropped = 1;
        grant = 0;
        repeat (5) step();
        grant = 1;
      end
      step();
    end
    exp_ids = '{1, 2, 2, 2, 4};
    check_ids("ids_grant_drop", exp_ids);

    // data_valid low for 3 cycles mid-body
    clear_cap();
    dropped = 0;
    launch(5, 7);
    for (int i = 0; i < 30; i++) begin
      if (dropped == 0 && count_id(2) == 1) begin
        dropped = 1;
        data_valid = 0;
        repeat (3) step();
        data_valid = 1;
      end
      step();
    end
    exp_ids = '{1, 2, 2, 2, 2, 4};
    check_ids("ids_dv_gap", exp_ids);

    // asynchronous reset in the middle of the body
    clear_cap();
    launch(6, 2);
    repeat (4) step();
    #2 rst = 1;
    #1;
    chk("arst_req", 32'(req), 0);
    chk("arst_flit_valid", 32'(flit_valid), 0);
    chk("arst_flit_id", 32'(flit_id), 0);
    chk("arst_data_ready", 32'(data_ready), 0);
    chk("arst_length", 32'(length), 0);
    model_reset();
    step();
    rst = 0;
    step();
    clear_cap();
    launch(2, 4);
    repeat (8) step();
    exp_ids = '{1, 2, 4};
    check_ids("ids_after_rst", exp_ids);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int sel;
      pkt_start  = ($urandom_range(0, 99) < 30);
      sel        = $urandom_range(0, 7);
      case (sel)
        0: pkt_len = 12'd0;
        1: pkt_len = 12'hFFF;
        2: pkt_len = 12'd1;
        3: pkt_len = 12'd2;
        default: pkt_len = 12'($urandom_range(1, 12));
      endcase
      pkt_dest   = DEST_W'($urandom());
      grant      = ($urandom_range(0, 99) < 70);
      data_valid = ($urandom_range(0, 99) < 70);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
